// File: rtl/seg_pkg.sv
// Shared seven-segment constants: cathode patterns, anode selects and the
// receive-side frame FSM encoding. The display driver uses the same table.
package seg_pkg;

  // Active-low cathodes, bit6 = a ... bit0 = g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  // Active-low digit enables
  localparam logic [3:0] AN_D3 = 4'b0111;
  localparam logic [3:0] AN_D2 = 4'b1011;
  localparam logic [3:0] AN_D1 = 4'b1101;
  localparam logic [3:0] AN_D0 = 4'b1110;

  // State value equals the index of the digit it waits for, so the expected
  // digit can be compared directly against the decoded anode index.
  typedef enum logic [1:0] {
    WAIT_D3 = 2'd3,
    WAIT_D2 = 2'd2,
    WAIT_D1 = 2'd1,
    WAIT_D0 = 2'd0
  } frame_state_t;

  // Anode select -> {legal, digit index}; blanking or multi-digit is illegal
  function automatic logic [2:0] an_decode(input logic [3:0] an);
    case (an)
      AN_D3:   return 3'b111;
      AN_D2:   return 3'b110;
      AN_D1:   return 3'b101;
      AN_D0:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational cathode-pattern to BCD digit decoder.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_cathodes,
  output logic       o_valid,
  output logic [3:0] o_digit
);

  // Map each legal pattern to its digit; anything else is flagged invalid
  always_comb begin
    o_valid = 1'b1;
    o_digit = 4'd0;
    case (i_cathodes)
      SEG_0:   o_digit = 4'd0;
      SEG_1:   o_digit = 4'd1;
      SEG_2:   o_digit = 4'd2;
      SEG_3:   o_digit = 4'd3;
      SEG_4:   o_digit = 4'd4;
      SEG_5:   o_digit = 4'd5;
      SEG_6:   o_digit = 4'd6;
      SEG_7:   o_digit = 4'd7;
      SEG_8:   o_digit = 4'd8;
      SEG_9:   o_digit = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side monitor for a four-digit multiplexed seven-segment display:
// debounces each anode/cathode pair, checks thousands->ones scan order and
// publishes each complete frame as BCD and binary.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anode_select,
  input  logic [6:0]  LED_out,
  output logic [15:0] bcd,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        frame_error,
  output logic        decode_error
);

  // Counter value seen (before update) on the edge that completes the dwell
  localparam logic [7:0] CAP_CNT = 8'(SETTLE_CYCLES - 2);

  logic [10:0]  w_pair;
  logic [10:0]  r_prev_pair;
  logic [7:0]   r_stable_cnt;
  logic [2:0]   w_an_dec;
  logic         w_an_valid;
  logic [1:0]   w_an_idx;
  logic         w_seg_valid;
  logic [3:0]   w_digit;
  logic         w_capture;

  frame_state_t r_state;
  frame_state_t w_state_next;
  logic [3:1]   w_store;
  logic         w_clear;
  logic         w_complete;
  logic         w_frame_err;
  logic         w_decode_err;

  logic [3:0]   r_digit [3:1];
  logic [13:0]  w_value_bin;

  assign w_pair     = {anode_select, LED_out};
  assign w_an_dec   = an_decode(anode_select);
  assign w_an_valid = w_an_dec[2];
  assign w_an_idx   = w_an_dec[1:0];

  seg_pattern_decode u_pattern_decode (
    .i_cathodes (LED_out),
    .o_valid    (w_seg_valid),
    .o_digit    (w_digit)
  );

  // Track the previous pair and how long it has been stable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_pair  <= '1;
      r_stable_cnt <= 8'd0;
    end else begin
      r_prev_pair <= w_pair;
      if (w_pair != r_prev_pair)
        r_stable_cnt <= 8'd0;
      else if (r_stable_cnt != 8'd255)
        r_stable_cnt <= r_stable_cnt + 8'd1;
    end
  end

  // One capture per dwell: the counter passes CAP_CNT only once per stable pair
  assign w_capture = w_an_valid && (w_pair == r_prev_pair) && (r_stable_cnt == CAP_CNT);

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_D3;
    else       r_state <= w_state_next;
  end

  // Frame FSM next state
  always_comb begin
    w_state_next = r_state;
    if (w_capture) begin
      if (!w_seg_valid) begin
        w_state_next = WAIT_D3;
      end else if (w_an_idx == r_state) begin
        case (r_state)
          WAIT_D3: w_state_next = WAIT_D2;
          WAIT_D2: w_state_next = WAIT_D1;
          WAIT_D1: w_state_next = WAIT_D0;
          default: w_state_next = WAIT_D3;
        endcase
      end else if (w_an_idx == 2'd3) begin
        // A stray thousands digit starts a fresh frame
        w_state_next = WAIT_D2;
      end else begin
        w_state_next = WAIT_D3;
      end
    end
  end

  // Frame FSM outputs: staging strobes, completion and error events
  always_comb begin
    w_store      = '0;
    w_clear      = 1'b0;
    w_complete   = 1'b0;
    w_frame_err  = 1'b0;
    w_decode_err = 1'b0;
    if (w_capture) begin
      if (!w_seg_valid) begin
        w_decode_err = 1'b1;
        w_clear      = 1'b1;
      end else if (w_an_idx == r_state) begin
        case (r_state)
          WAIT_D3: w_store[3] = 1'b1;
          WAIT_D2: w_store[2] = 1'b1;
          WAIT_D1: w_store[1] = 1'b1;
          default: begin
            w_complete = 1'b1;
            w_clear    = 1'b1;
          end
        endcase
      end else begin
        w_frame_err = 1'b1;
        w_clear     = 1'b1;
        if (w_an_idx == 2'd3) w_store[3] = 1'b1;
      end
    end
  end

  // Digit staging; a store overrides a simultaneous clear of the same slot
  for (genvar gi = 1; gi <= 3; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (reset)            r_digit[gi] <= 4'd0;
      else if (w_store[gi]) r_digit[gi] <= w_digit;
      else if (w_clear)     r_digit[gi] <= 4'd0;
    end
  end

  // Binary value of the frame being completed (max 9999 fits in 14 bits)
  assign w_value_bin = 14'(r_digit[3]) * 14'd1000
                     + 14'(r_digit[2]) * 14'd100
                     + 14'(r_digit[1]) * 14'd10
                     + 14'(w_digit);

  // Publish completed frames and one-cycle event pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd          <= 16'd0;
      value        <= 16'd0;
      value_valid  <= 1'b0;
      frame_error  <= 1'b0;
      decode_error <= 1'b0;
    end else begin
      value_valid  <= w_complete;
      frame_error  <= w_frame_err;
      decode_error <= w_decode_err;
      if (w_complete) begin
        bcd   <= {r_digit[3], r_digit[2], r_digit[1], w_digit};
        value <= {2'b00, w_value_bin};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with SETTLE_CYCLES = 4.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode_select;
  logic [6:0]  LED_out;
  logic [15:0] bcd;
  logic [15:0] value;
  logic        value_valid;
  logic        frame_error;
  logic        decode_error;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_vv = 0;
  int cnt_fe = 0;
  int cnt_de = 0;
  int b_vv, b_fe, b_de;

  // Bench-local copy of the cathode table, independent of the RTL package
  logic [6:0] seg_tab [10];
  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
    seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
    seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;
  end

  localparam logic [3:0] A3 = 4'b0111, A2 = 4'b1011, A1 = 4'b1101, A0 = 4'b1110;
  localparam logic [3:0] ABLANK = 4'b1111;

  always #5 clk = ~clk;

  seg_scan_decoder #(.SETTLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .anode_select (anode_select),
    .LED_out      (LED_out),
    .bcd          (bcd),
    .value        (value),
    .value_valid  (value_valid),
    .frame_error  (frame_error),
    .decode_error (decode_error)
  );

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (value_valid)  cnt_vv++;
    if (frame_error)  cnt_fe++;
    if (decode_error) cnt_de++;
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s: %0d (0x%h)", tag, got, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg);
    anode_select = an;
    LED_out      = seg;
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    drive(an, seg);
    repeat (n) tick();
  endtask

  task automatic frame(input int d3, input int d2, input int d1, input int d0, input int n);
    hold(A3, seg_tab[d3], n);
    hold(A2, seg_tab[d2], n);
    hold(A1, seg_tab[d1], n);
    hold(A0, seg_tab[d0], n);
  endtask

  task automatic snap();
    b_vv = cnt_vv;
    b_fe = cnt_fe;
    b_de = cnt_de;
  endtask

  initial begin
    reset = 1'b1;
    drive(ABLANK, 7'h7F);
    repeat (3) tick();
    check_val("rst_bcd", bcd, 16'h0000);
    check_val("rst_value", value, 16'd0);
    check_val("rst_vv", {15'd0, value_valid}, 16'd0);
    check_val("rst_fe", {15'd0, frame_error}, 16'd0);
    check_val("rst_de", {15'd0, decode_error}, 16'd0);
    reset = 1'b0;
    tick();

    // Full frame 1234 with exact ones-digit latency
    snap();
    hold(A3, seg_tab[1], 6);
    hold(A2, seg_tab[2], 6);
    hold(A1, seg_tab[3], 6);
    drive(A0, seg_tab[4]);
    repeat (3) tick();
    check_val("full_vv_early", {15'd0, value_valid}, 16'd0);
    tick();
    check_val("full_vv_edge4", {15'd0, value_valid}, 16'd1);
    check_val("full_bcd", bcd, 16'h1234);
    check_val("full_value", value, 16'd1234);
    tick();
    check_val("full_vv_drop", {15'd0, value_valid}, 16'd0);
    tick();
    check_val("full_vv_count", 16'(cnt_vv - b_vv), 16'd1);

    // Glitch rejection: blanking and a short ones dwell inside the frame
    snap();
    hold(A3, seg_tab[9], 6);
    hold(ABLANK, 7'h7F, 2);
    hold(A2, seg_tab[9], 6);
    hold(A0, seg_tab[7], 2);
    hold(A1, seg_tab[9], 6);
    hold(ABLANK, 7'h7F, 2);
    hold(A0, seg_tab[9], 6);
    check_val("glitch_value", value, 16'd9999);
    check_val("glitch_bcd", bcd, 16'h9999);
    check_val("glitch_vv_count", 16'(cnt_vv - b_vv), 16'd1);
    check_val("glitch_err_count", 16'((cnt_fe - b_fe) + (cnt_de - b_de)), 16'd0);

    // Order error: thousands then tens
    snap();
    hold(A3, seg_tab[5], 6);
    hold(A1, seg_tab[3], 6);
    check_val("order_fe_count", 16'(cnt_fe - b_fe), 16'd1);
    check_val("order_value_hold", value, 16'd9999);
    check_val("order_vv_count", 16'(cnt_vv - b_vv), 16'd0);
    frame(0, 0, 0, 8, 6);
    check_val("order_next_value", value, 16'd8);
    check_val("order_next_bcd", bcd, 16'h0008);

    // Decode error on the hundreds digit
    snap();
    hold(A3, seg_tab[2], 6);
    hold(A2, 7'b1111111, 10);
    check_val("dec_de_count", 16'(cnt_de - b_de), 16'd1);
    check_val("dec_fe_count", 16'(cnt_fe - b_fe), 16'd0);
    check_val("dec_vv_count", 16'(cnt_vv - b_vv), 16'd0);
    check_val("dec_value_hold", value, 16'd8);

    // Reset mid-frame after d3 and d2 captured
    hold(A3, seg_tab[7], 6);
    hold(A2, seg_tab[7], 6);
    reset = 1'b1;
    hold(ABLANK, 7'h7F, 2);
    check_val("rstmid_value", value, 16'd0);
    check_val("rstmid_bcd", bcd, 16'h0000);
    reset = 1'b0;
    snap();
    hold(A1, seg_tab[7], 6);
    hold(A0, seg_tab[7], 6);
    check_val("rstmid_no_vv", 16'(cnt_vv - b_vv), 16'd0);
    check_val("rstmid_value_after", value, 16'd0);

    // Reset on the completing ones edge
    frame(1, 1, 1, 1, 6);
    check_val("pre_rst_value", value, 16'd1111);
    snap();
    hold(A3, seg_tab[6], 6);
    hold(A2, seg_tab[6], 6);
    hold(A1, seg_tab[6], 6);
    drive(A0, seg_tab[6]);
    repeat (3) tick();
    reset = 1'b1;
    drive(ABLANK, 7'h7F);
    tick();
    reset = 1'b0;
    tick();
    check_val("rstcmp_value", value, 16'd0);
    check_val("rstcmp_bcd", bcd, 16'h0000);
    check_val("rstcmp_no_vv", 16'(cnt_vv - b_vv), 16'd0);
    frame(4, 3, 2, 1, 6);
    check_val("clean_value", value, 16'd4321);
    check_val("clean_bcd", bcd, 16'h4321);

    // Loopback-style back-to-back frames at minimum dwell
    snap();
    repeat (3) frame(9, 8, 7, 6, 4);
    tick();
    check_val("loop_vv_count", 16'(cnt_vv - b_vv), 16'd3);
    check_val("loop_value", value, 16'd9876);
    check_val("loop_bcd", bcd, 16'h9876);
    check_val("loop_err_count", 16'((cnt_fe - b_fe) + (cnt_de - b_de)), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side counterpart of the four-digit seven-segment scan controller. It watches the multiplexed anode-select and cathode lines, decodes each settled digit, and checks the scan order (thousands → ones). On each complete frame it emits the displayed number as BCD and binary with a one-cycle valid strobe. It sits in self-checking benches and in on-board loopback monitors, next to the display driver.

## Interface
- `SETTLE_CYCLES`, default 4: consecutive identical samples required before a digit is captured; legal range 2..255.

Ports:
- `clk`  in  1  system clock, 100 MHz
- `reset`  in  1  synchronous, active-high
- `anode_select`  in  4  active-low digit enables; 0111 = thousands, 1011 = hundreds, 1101 = tens, 1110 = ones
- `LED_out`  in  7  active-low cathodes, bit6 = a … bit0 = g
- `bcd`  out  16  last complete frame: {d3, d2, d1, d0}, 4 bits per digit
- `value`  out  16  binary of `bcd`, range 0..9999, zero-extended
- `value_valid`  out  1  one-cycle pulse when `bcd` and `value` update
- `frame_error`  out  1  one-cycle pulse on an out-of-order digit capture
- `decode_error`  out  1  one-cycle pulse on a captured cathode pattern outside the 0..9 table

## Operation
- **Pair sampling:** pair = {anode_select, LED_out}, sampled every edge.
  - `prev_pair` holds the previous sample.
  - `stable_cnt` (8-bit) clears when pair ≠ `prev_pair`, else increments, saturating at 255.
- **Capture:** occurs on the edge where the pair has been identical for SETTLE_CYCLES consecutive samples, that edge included.
  - Exactly one capture per dwell; a new capture requires a pair change first.
- **Illegal anode:** any pattern other than the four one-hot-low values (e.g. 1111 blanking, or two digits low) never captures and raises no error.
- **Cathode decode:** 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100.
  - Any other pattern is invalid.
- **Frame FSM states:** WAIT_D3, WAIT_D2, WAIT_D1, WAIT_D0; reset state is WAIT_D3.
  - Capture of the expected digit with a valid pattern: store the digit, advance to the next state.
  - Capture in WAIT_D0 with a valid pattern: transfer digits to outputs, pulse `value_valid`, return to WAIT_D3.
  - Capture with an invalid pattern: pulse `decode_error`, discard partial digits, go to WAIT_D3. Takes precedence over `frame_error`.
  - Capture of an unexpected digit with a valid pattern: pulse `frame_error`, discard partial digits.
    - If the captured digit is thousands: store it and go to WAIT_D2.
    - Otherwise: go to WAIT_D3.
- **Arithmetic:** value = d3·1000 + d2·100 + d1·10 + d0.
  - Computed combinationally from the staged digits.
  - Registered on the completing edge; 14 bits of result, upper 2 bits of `value` are 0.
- `bcd` and `value` hold until the next complete frame.

## Timing
- Reset values:
  - Outputs: `bcd` = 0, `value` = 0, `value_valid` = 0, `frame_error` = 0, `decode_error` = 0.
  - Internal: `prev_pair` = all ones, `stable_cnt` = 0, FSM in WAIT_D3, staged digits 0.
- Pair changes before edge 0 and then holds: capture on edge SETTLE_CYCLES−1.
- For the ones digit, `bcd`, `value` and `value_valid` are visible after that same edge. Latency from pair change to `value_valid` is SETTLE_CYCLES edges.
- Error pulses are asserted for exactly the one cycle following the capture edge.
- A dwell shorter than SETTLE_CYCLES produces no capture. The FSM state is unchanged and no error is raised.
- Reset asserted on the same edge as a completing capture: reset wins, no `value_valid`, outputs go to 0.
- Reset mid-frame: partial digits are discarded.
- Throughput: one frame per 4·SETTLE_CYCLES cycles minimum; back-to-back frames are supported with no idle cycles.

## Structure
- Shared package/include `seg_pkg`:
  - Cathode constants SEG_0..SEG_9.
  - Anode constants AN_D3, AN_D2, AN_D1, AN_D0.
  - FSM state encodings.
  - These are shared with the display driver so both ends use one table.
- Sub-module `seg_pattern_decode`: combinational, 7-bit cathodes in, {valid, digit[3:0]} out.
- Top level holds the sampling register, settle counter, FSM, digit staging, and the binary conversion.

## Test plan
- **Full frame:** reset, then drive 0111/SEG_1, 1011/SEG_2, 1101/SEG_3, 1110/SEG_4, each held 6 cycles, SETTLE_CYCLES = 4 → one `value_valid` pulse, `bcd` = 16'h1234, `value` = 1234, exactly 4 edges after the ones pair appears.
- **Glitch rejection:** insert 1111 blanking for 2 cycles and a 2-cycle dwell 1110/SEG_7 inside the frame for 9,9,9,9 → `value` = 9999, no error pulses.
- **Order error:** capture thousands 5, then tens 3 → `frame_error` pulse, FSM back to WAIT_D3, `value` unchanged. A following full frame 0,0,0,8 → `value` = 8.
- **Decode error:** hundreds pattern 1111111 held 10 cycles → one `decode_error` pulse only, partial frame discarded, no `value_valid`.
- **Reset interaction:** reset asserted mid-frame after d3 and d2 are captured, and separately on the completing ones edge → outputs 0, no `value_valid`. The next clean frame 4,3,2,1 → `value` = 4321.
- **Loopback:** connect to the display driver with count = 9876 and a shortened refresh counter → `value_valid` repeatedly with `value` = 9876 and no errors.
